// File: rtl/load_ship_if.sv
// Handshake/status bundle between the ship-loading sequencer and its driver.
// Member suffixes are named from the sequencer's point of view (slave side).
interface load_ship_if #(
  parameter int CNT_W = 4
) ();
  logic             start_i;
  logic             board_valid_i;
  logic [1:0]       board_type_i;
  logic             board_ready_o;
  logic             launch_ack_i;
  logic             clear_i;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] pass_cnt_o;
  logic [CNT_W-1:0] crew_cnt_o;
  logic [CNT_W-1:0] cargo_cnt_o;
  logic             ship_loaded_o;
  logic [1:0]       err_code_o;

  modport slave (
    input  start_i, board_valid_i, board_type_i, launch_ack_i, clear_i,
    output board_ready_o, state_o, pass_cnt_o, crew_cnt_o, cargo_cnt_o,
           ship_loaded_o, err_code_o
  );

  modport master (
    output start_i, board_valid_i, board_type_i, launch_ack_i, clear_i,
    input  board_ready_o, state_o, pass_cnt_o, crew_cnt_o, cargo_cnt_o,
           ship_loaded_o, err_code_o
  );
endinterface

// File: rtl/load_ship_ctrl.sv
// Ship-loading sequencer: counts passenger/crew/cargo boarding events, declares
// the ship loaded when all targets are met, and enforces a loading timeout.
//
// state  | meaning
// REST   | idle, counts held at 0, waiting for start
// LOAD   | accepting boarding events, timeout running
// LOADED | all targets met, waiting for launch_ack
// ERROR  | timeout / illegal type / overflow, waiting for clear
module load_ship_ctrl #(
  parameter int CNT_W     = 4,
  parameter int PASS_MAX  = 15,
  parameter int CREW_REQ  = 4,
  parameter int CARGO_MAX = 15,
  parameter int TMO_W     = 8,
  parameter int TIMEOUT   = 200
) (
  input logic       clk,
  input logic       rst,
  load_ship_if.slave bus
);

  typedef enum logic [2:0] {
    ST_REST   = 3'b000,
    ST_LOAD   = 3'b001,
    ST_LOADED = 3'b010,
    ST_ERROR  = 3'b111
  } state_e;

  localparam logic [CNT_W-1:0] PASS_CAP  = CNT_W'(PASS_MAX);
  localparam logic [CNT_W-1:0] CREW_CAP  = CNT_W'(CREW_REQ);
  localparam logic [CNT_W-1:0] CARGO_CAP = CNT_W'(CARGO_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] pass_q, crew_q, cargo_q;
  logic [CNT_W-1:0] pass_d, crew_d, cargo_d;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       err_q;
  logic             loaded_q;

  logic [CNT_W-1:0] sel_cnt, sel_cap;
  logic             illegal, ready, accept, overflow, loaded_d, tmo_last;

  always_comb begin
    sel_cnt = '0;
    sel_cap = '0;
    case (bus.board_type_i)
      2'd0: begin sel_cnt = pass_q;  sel_cap = PASS_CAP;  end
      2'd1: begin sel_cnt = crew_q;  sel_cap = CREW_CAP;  end
      2'd2: begin sel_cnt = cargo_q; sel_cap = CARGO_CAP; end
      default: ;
    endcase
  end

  // Illegal types are always accepted so they can be flagged as errors.
  assign illegal  = (bus.board_type_i == 2'd3);
  assign ready    = (state_q == ST_LOAD) && (illegal || (sel_cnt < sel_cap));
  assign accept   = bus.board_valid_i && ready;
  assign overflow = (state_q == ST_LOAD) && bus.board_valid_i && !ready && !illegal;

  assign pass_d  = (accept && bus.board_type_i == 2'd0) ? pass_q + CNT_ONE  : pass_q;
  assign crew_d  = (accept && bus.board_type_i == 2'd1) ? crew_q + CNT_ONE  : crew_q;
  assign cargo_d = (accept && bus.board_type_i == 2'd2) ? cargo_q + CNT_ONE : cargo_q;

  // Completion is judged on post-update counts so the final event lands in LOADED directly.
  assign loaded_d = (pass_d == PASS_CAP) && (crew_d == CREW_CAP) && (cargo_d == CARGO_CAP);
  assign tmo_last = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_REST;
      pass_q   <= '0;
      crew_q   <= '0;
      cargo_q  <= '0;
      tmo_q    <= '0;
      err_q    <= 2'd0;
      loaded_q <= 1'b0;
    end else begin
      case (state_q)
        ST_REST: begin
          pass_q  <= '0;
          crew_q  <= '0;
          cargo_q <= '0;
          err_q   <= 2'd0;
          if (bus.start_i) begin
            state_q <= ST_LOAD;
            tmo_q   <= '0;
          end
        end
        ST_LOAD: begin
          tmo_q <= tmo_q + TMO_ONE;
          if (accept && illegal) begin
            state_q <= ST_ERROR;
            err_q   <= 2'd2;
          end else if (overflow) begin
            state_q <= ST_ERROR;
            err_q   <= 2'd3;
          end else begin
            pass_q  <= pass_d;
            crew_q  <= crew_d;
            cargo_q <= cargo_d;
            if (loaded_d) begin
              state_q  <= ST_LOADED;
              loaded_q <= 1'b1;
            end else if (tmo_last) begin
              state_q <= ST_ERROR;
              err_q   <= 2'd1;
            end
          end
        end
        ST_LOADED: begin
          if (bus.launch_ack_i) begin
            state_q  <= ST_REST;
            loaded_q <= 1'b0;
            pass_q   <= '0;
            crew_q   <= '0;
            cargo_q  <= '0;
          end
        end
        ST_ERROR: begin
          if (bus.clear_i) begin
            state_q <= ST_REST;
            err_q   <= 2'd0;
            pass_q  <= '0;
            crew_q  <= '0;
            cargo_q <= '0;
          end
        end
        default: state_q <= ST_REST;
      endcase
    end
  end

  assign bus.board_ready_o = ready;
  assign bus.state_o       = state_q;
  assign bus.pass_cnt_o    = pass_q;
  assign bus.crew_cnt_o    = crew_q;
  assign bus.cargo_cnt_o   = cargo_q;
  assign bus.ship_loaded_o = loaded_q;
  assign bus.err_code_o    = err_q;

endmodule

// File: tb/tb_load_ship_ctrl.sv
// Bench for load_ship_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a counting model of the loading rules.
module tb_load_ship_ctrl;

  localparam int CNT_W     = 4;
  localparam int PASS_MAX  = 15;
  localparam int CREW_REQ  = 4;
  localparam int CARGO_MAX = 15;
  localparam int TIMEOUT   = 200;

  logic clk;
  logic rst;
  load_ship_if #(.CNT_W(CNT_W)) bus ();

  load_ship_ctrl #(
    .CNT_W(CNT_W), .PASS_MAX(PASS_MAX), .CREW_REQ(CREW_REQ),
    .CARGO_MAX(CARGO_MAX), .TMO_W(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0=REST 1=LOAD 2=LOADED 7=ERROR; cnt[0..2]; cycles spent in LOAD.
  int m_mode;
  int m_cnt [3];
  int m_err;
  int m_cycles;
  int caps [3] = '{PASS_MAX, CREW_REQ, CARGO_MAX};

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_ready();
    int t = int'(bus.board_type_i);
    if (m_mode != 1) return 0;
    if (t == 3) return 1;
    return (m_cnt[t] < caps[t]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_err = 0; m_cycles = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    int r = model_ready();
    int t = int'(bus.board_type_i);
    case (m_mode)
      0: if (bus.start_i) begin m_mode = 1; m_cycles = 0; end
      1: begin
        m_cycles++;
        if (bus.board_valid_i && t == 3) begin
          m_mode = 7; m_err = 2;
        end else if (bus.board_valid_i && r == 0) begin
          m_mode = 7; m_err = 3;
        end else begin
          if (bus.board_valid_i) m_cnt[t]++;
          if (m_cnt[0] == PASS_MAX && m_cnt[1] == CREW_REQ && m_cnt[2] == CARGO_MAX)
            m_mode = 2;
          else if (m_cycles == TIMEOUT) begin
            m_mode = 7; m_err = 1;
          end
        end
      end
      2: if (bus.launch_ack_i) begin m_mode = 0; foreach (m_cnt[i]) m_cnt[i] = 0; end
      7: if (bus.clear_i) begin m_mode = 0; m_err = 0; foreach (m_cnt[i]) m_cnt[i] = 0; end
      default: ;
    endcase
  endtask

  task automatic check_outs();
    chk("state",       int'(bus.state_o),       m_mode);
    chk("pass_cnt",    int'(bus.pass_cnt_o),    m_cnt[0]);
    chk("crew_cnt",    int'(bus.crew_cnt_o),    m_cnt[1]);
    chk("cargo_cnt",   int'(bus.cargo_cnt_o),   m_cnt[2]);
    chk("err_code",    int'(bus.err_code_o),    m_err);
    chk("ship_loaded", int'(bus.ship_loaded_o), (m_mode == 2) ? 1 : 0);
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks both phases.
  task automatic cyc(input logic s, input logic v, input logic [1:0] t,
                     input logic a, input logic c);
    bus.start_i = s; bus.board_valid_i = v; bus.board_type_i = t;
    bus.launch_ack_i = a; bus.clear_i = c;
    @(negedge clk);
    chk("board_ready", int'(bus.board_ready_o), model_ready());
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic events(input logic [1:0] t, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, t, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    bus.start_i = 0; bus.board_valid_i = 0; bus.board_type_i = 0;
    bus.launch_ack_i = 0; bus.clear_i = 0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    chk("ready_in_reset", int'(bus.board_ready_o), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 0; bus.board_valid_i = 0; bus.board_type_i = 0;
    bus.launch_ack_i = 0; bus.clear_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_outs();
    chk("ready_after_reset", int'(bus.board_ready_o), 0);
    rst = 1'b0;

    // Full load back-to-back, then launch.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("enter_load", int'(bus.state_o), 1);
    events(2'd0, PASS_MAX);
    events(2'd1, CREW_REQ);
    events(2'd2, CARGO_MAX - 1);
    chk("not_yet_loaded", int'(bus.state_o), 1);
    events(2'd2, 1);
    chk("loaded_state", int'(bus.state_o), 2);
    chk("loaded_flag", int'(bus.ship_loaded_o), 1);
    idle(2);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("ack_to_rest", int'(bus.state_o), 0);
    chk("ack_clears_pass", int'(bus.pass_cnt_o), 0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("reenter_load", int'(bus.state_o), 1);

    // Crew overflow attempt.
    events(2'd1, CREW_REQ);
    events(2'd1, 1);
    chk("ovf_state", int'(bus.state_o), 7);
    chk("ovf_err", int'(bus.err_code_o), 3);
    chk("ovf_crew_held", int'(bus.crew_cnt_o), CREW_REQ);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("start_ignored_in_error", int'(bus.state_o), 7);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

    // Illegal type.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    events(2'd0, 2);
    events(2'd3, 1);
    chk("illegal_err", int'(bus.err_code_o), 2);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("clear_err", int'(bus.err_code_o), 0);

    // Timeout: exactly TIMEOUT cycles in LOAD.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(TIMEOUT - 1);
    chk("tmo_not_yet", int'(bus.state_o), 1);
    idle(1);
    chk("tmo_state", int'(bus.state_o), 7);
    chk("tmo_err", int'(bus.err_code_o), 1);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

    // Final event on the timeout cycle wins.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    events(2'd0, PASS_MAX);
    events(2'd1, CREW_REQ);
    events(2'd2, CARGO_MAX - 1);
    idle(TIMEOUT - (PASS_MAX + CREW_REQ + CARGO_MAX));
    events(2'd2, 1);
    chk("last_on_tmo_state", int'(bus.state_o), 2);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

    // Async reset mid-load at 7/2/3.
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    events(2'd0, 7);
    events(2'd1, 2);
    events(2'd2, 3);
    chk("pre_reset_pass", int'(bus.pass_cnt_o), 7);
    async_reset();

    // Random traffic, mostly steering toward counts below their caps.
    for (int n = 0; n < 4000; n++) begin
      logic [1:0] t;
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) t = 2'($urandom_range(0, 3));
        else begin
          t = 2'($urandom_range(0, 2));
          for (int k = 0; k < 3; k++)
            if (m_cnt[int'(t)] >= caps[int'(t)]) t = (t == 2'd2) ? 2'd0 : t + 2'd1;
        end
        cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), t,
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_ship_ctrl.md
Name: load_ship_ctrl

Overview:
- Sequential, parametrised successor to the combinational ship-loading check in the time-machine state flow.
- Accepts boarding events one per cycle through a valid/ready handshake and keeps running passenger, crew and cargo counts.
- Declares the ship loaded only when every count reaches its target, and enforces a loading timeout.
- Drives the 3-bit machine state: REST 3'b000, LOAD 3'b001, LOADED 3'b010, ERROR 3'b111.

Parameters:
- CNT_W, 4, width of each count register and count output.
- PASS_MAX, 15, passenger target and hard cap; must be ≤ 2^CNT_W−1.
- CREW_REQ, 4, exact crew count required; must be ≤ 2^CNT_W−1.
- CARGO_MAX, 15, cargo target and hard cap; must be ≤ 2^CNT_W−1.
- TMO_W, 8, timeout counter width.
- TIMEOUT, 200, maximum cycles allowed in LOAD; must be ≥ 1 and ≤ 2^TMO_W−1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; REST→LOAD request.
- board_valid  in  1  boarding event offered.
- board_type  in  2  0 = passenger, 1 = crew, 2 = cargo, 3 = illegal.
- board_ready  out  1  event will be accepted this cycle.
- launch_ack  in  1  downstream consumed LOADED.
- clear  in  1  leave ERROR.
- state  out  3  current state encoding.
- pass_cnt  out  CNT_W  passengers aboard.
- crew_cnt  out  CNT_W  crew aboard.
- cargo_cnt  out  CNT_W  cargo units aboard.
- ship_loaded  out  1  high exactly while state == LOADED.
- err_code  out  2  0 none, 1 timeout, 2 illegal type, 3 overflow attempt.

Behaviour:
- **Reset (async, any time, including mid-LOAD):**
  - state = REST; all counts 0; timeout counter 0; err_code 0; ship_loaded 0; board_ready 0.
  - No event in flight survives reset.
- **board_ready (combinational):** 1 only in LOAD, and only when the count selected by board_type is below its cap (PASS_MAX, CREW_REQ, CARGO_MAX).
  - For type 3, board_ready = 1 so the illegal event is accepted and flagged.
  - 0 in all other states.
- **Accept:** board_valid & board_ready at a rising edge.
  - The selected count increments by exactly 1 and is visible the next cycle.
  - At most one increment per cycle; counts never wrap.
- **Overflow attempt:** board_valid with board_ready = 0 while in LOAD, for type 0–2 → next state ERROR, err_code = 3, counts unchanged.
- **REST:**
  - Counts held at 0.
  - start = 1 → LOAD next cycle; timeout counter cleared.
  - board_valid is ignored.
- **LOAD:** timeout counter increments every cycle. Transition rules, in priority order:
  1. An accepted event with type 3 → ERROR, err_code = 2.
  2. Overflow attempt → ERROR, err_code = 3.
  3. Loaded condition, evaluated on post-update counts (pass == PASS_MAX & crew == CREW_REQ & cargo == CARGO_MAX) → LOADED. The final event therefore completes in the same edge that enters LOADED.
  4. Timeout counter == TIMEOUT−1 with the load still incomplete → ERROR, err_code = 1.
  - A simultaneous final-load event and timeout resolves to LOADED.
- **LOADED:**
  - ship_loaded = 1; counts frozen.
  - launch_ack = 1 → REST next cycle; counts cleared to 0.
  - No timeout applies.
- **ERROR:**
  - Counts and err_code frozen.
  - clear = 1 → REST next cycle; counts and err_code cleared.
  - start is ignored while in ERROR.
- **Hold behaviour:** all outputs are registered except board_ready; if no transition condition is met, state holds.

Test Plan:
- Reset, start, then 15 passenger, 4 crew and 15 cargo events back-to-back → state reaches 3'b010 on the edge of the 34th accept; ship_loaded = 1; counts 15/4/15.
- LOADED, then launch_ack pulse → state 3'b000 next cycle; all counts 0; a subsequent start re-enters 3'b001.
- In LOAD with crew_cnt = 4, assert board_valid with type 1 → board_ready = 0; state 3'b111; err_code = 3; crew_cnt stays 4.
- In LOAD, one event with type 3 → state 3'b111 and err_code = 2; then clear → 3'b000 with err_code 0.
- Start with no events for TIMEOUT cycles → state 3'b111 and err_code = 1 after exactly 200 cycles in LOAD. Repeat with the final loading event landing on cycle 200 → state 3'b010.
- Assert rst asynchronously mid-LOAD with counts 7/2/3 → state 3'b000 and counts 0 immediately, without a clock edge.
